// File: rtl/mem_block_pkg.sv
// Shared definitions for the memory block master: op encodings, FSM states and size defaults.
package mem_block_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DEPTH  = 7680;
    localparam int DATA_W     = 32;
    localparam int BE_W       = DATA_W / 8;

    typedef enum logic [1:0] {
        OP_FILL_CONST = 2'b00,
        OP_FILL_INC   = 2'b01,
        OP_READ       = 2'b10,
        OP_RSVD       = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mem_block_master_if.sv
// Command, Avalon-MM initiator, read-stream and status signals of the memory block master.
interface mem_block_master_if
    import mem_block_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic [BE_W-1:0]   cmd_byteenable;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, cmd_byteenable,
        input  readdata, rd_ready,
        output cmd_ready, address, byteenable, chipselect, write, writedata, clken,
        output rd_valid, rd_data, done, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, cmd_byteenable,
        output readdata, rd_ready,
        input  cmd_ready, address, byteenable, chipselect, write, writedata, clken,
        input  rd_valid, rd_data, done, err
    );

endinterface

// File: rtl/mem_block_addr_gen.sv
// Word address / index counter for block transfers, with load, enable and last-word flag.
module mem_block_addr_gen #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_len,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] len_m1;

    // len is never zero when loaded, so len-1 cannot underflow
    always_ff @(posedge clk) begin
        if (reset) begin
            addr   <= '0;
            idx    <= '0;
            len_m1 <= '0;
        end else if (load) begin
            addr   <= load_addr;
            idx    <= '0;
            len_m1 <= load_len - 1'b1;
        end else if (en) begin
            addr   <= addr + 1'b1;
            idx    <= idx + 1'b1;
        end
    end

    assign last = (idx == len_m1);

endmodule

// File: rtl/mem_block_master.sv
// Block FILL/READ master for an Avalon-MM on-chip memory with a backpressured read stream.
// Optional checksum output enabled by defining MEM_BLOCK_MASTER_CHECKSUM_EN.
module mem_block_master
    import mem_block_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    mem_block_master_if.master bus
`ifdef MEM_BLOCK_MASTER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

    state_e            state;
    logic              cmd_ready_r;
    logic              cs_r;
    logic              wr_r;
    logic              vld_p1;
    logic              done_r;
    logic              err_r;
    logic              fill_inc;
    logic [DATA_W-1:0] wdata_r;
    logic [BE_W-1:0]   be_r;

    logic              accept;
    logic              cmd_bad;
    logic              cmd_empty;
    logic [ADDR_W+1:0] end_sum;
    logic              clken;
    logic              last;
    logic              cnt_load;
    logic              cnt_en;
    logic [ADDR_W-1:0] addr;

    assign accept    = cmd_ready_r && bus.cmd_valid;
    assign end_sum   = {2'b00, bus.cmd_addr} + {1'b0, bus.cmd_len};
    assign cmd_bad   = (bus.cmd_op == OP_RSVD) || (end_sum > DEPTH_W);
    assign cmd_empty = (bus.cmd_len == '0);

    // Memory output register is frozen while a presented word is stalled
    assign clken     = ~(vld_p1 & ~bus.rd_ready);

    assign cnt_load  = accept && !cmd_bad && !cmd_empty;
    assign cnt_en    = ((state == ST_FILL) || ((state == ST_READ) && clken)) && !last;

    mem_block_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_addr (bus.cmd_addr),
        .load_len  (bus.cmd_len),
        .en        (cnt_en),
        .addr      (addr),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            cs_r        <= 1'b0;
            wr_r        <= 1'b0;
            vld_p1      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            // Stage p1: a read address issued under clken yields valid data next cycle
            if (clken) begin
                vld_p1 <= cs_r & ~wr_r;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready_r <= 1'b0;
                        if (cmd_bad || cmd_empty) begin
                            state  <= ST_DONE;
                            done_r <= 1'b1;
                            err_r  <= cmd_bad;
                        end else if (bus.cmd_op == OP_READ) begin
                            state <= ST_READ;
                            cs_r  <= 1'b1;
                            wr_r  <= 1'b0;
                        end else begin
                            state <= ST_FILL;
                            cs_r  <= 1'b1;
                            wr_r  <= 1'b1;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (last) begin
                        state  <= ST_DONE;
                        cs_r   <= 1'b0;
                        wr_r   <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (clken && last) begin
                        state <= ST_DRAIN;
                        cs_r  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (vld_p1 && bus.rd_ready) begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    cs_r  <= 1'b0;
                    wr_r  <= 1'b0;
                end
            endcase
        end
    end

    // Write data path: seeded on accept, stepped per word for incrementing fills
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_r  <= bus.cmd_data;
            be_r     <= (bus.cmd_op == OP_READ) ? {BE_W{1'b1}} : bus.cmd_byteenable;
            fill_inc <= (bus.cmd_op == OP_FILL_INC);
        end else if ((state == ST_FILL) && fill_inc && !last) begin
            wdata_r  <= wdata_r + 32'd1;
        end
    end

`ifdef MEM_BLOCK_MASTER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (accept) begin
            checksum <= '0;
        end else if (vld_p1 && bus.rd_ready) begin
            checksum <= checksum + bus.readdata;
        end
    end
`endif

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.address    = addr;
    assign bus.byteenable = be_r;
    assign bus.chipselect = cs_r;
    assign bus.write      = wr_r;
    assign bus.writedata  = wdata_r;
    assign bus.clken      = clken;
    assign bus.rd_valid   = vld_p1;
    assign bus.rd_data    = bus.readdata;
    assign bus.done       = done_r;
    assign bus.err        = err_r;

endmodule

// File: doc/mem_block_master.md
MEM_BLOCK_MASTER -- requirements
Module: mem_block_master

Interface
REQ-001 Parameter: ADDR_W, default 13, word-address width of the attached memory.
REQ-002 Parameter: DEPTH, default 7680, number of 32-bit words in the attached memory.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid / cmd_ready  in/out  1/1  command handshake; accepted when both are high on a clk edge.
REQ-006 cmd_op  in  2  00 = FILL constant, 01 = FILL incrementing, 10 = READ, 11 = reserved.
REQ-007 cmd_addr / cmd_len  in  ADDR_W / ADDR_W+1  start word address and word count.
REQ-008 cmd_data / cmd_byteenable  in  32 / 4  fill seed and byte lanes for FILL ops.
REQ-009 address, byteenable, chipselect, write, writedata, clken  out  ADDR_W, 4, 1, 1, 32, 1  Avalon-MM initiator side, driving the on-chip memory slave.
REQ-010 readdata  in  32  memory read data, valid one clken-qualified cycle after its address.
REQ-011 rd_valid / rd_ready / rd_data  out/in/out  1/1/32  read-data stream output.
REQ-012 done / err  out  1/1  one-cycle completion pulse; err is valid when done is high.

Function
REQ-013 States: IDLE, FILL, READ, DRAIN, DONE; cmd_ready SHALL be high only in IDLE.
REQ-014 Command accept: if cmd_op = 11, or cmd_addr + cmd_len > DEPTH (computed at ADDR_W+2 bits, no wrap), the block SHALL go to DONE with err = 1 and issue no memory access.
REQ-015 cmd_len = 0 SHALL go to DONE with err = 0 and issue no memory access.
REQ-016 FILL: one write per cycle (chipselect = write = 1, byteenable = cmd_byteenable, clken = 1) at addresses cmd_addr .. cmd_addr+len-1.
REQ-017 FILL writedata SHALL be cmd_data for op 00, and cmd_data + i (mod 2^32) for op 01, where i is the word index.
REQ-018 READ: chipselect = 1, write = 0, byteenable = 4'hF; the address counter SHALL advance only on cycles where clken = 1.
REQ-019 rd_data SHALL equal readdata combinationally; rd_valid SHALL be registered high the cycle after each clken-qualified read address.
REQ-020 Backpressure: clken = ~(rd_valid & ~rd_ready), so the memory output holds while the stream stalls; no word is lost or duplicated.
REQ-021 After the last address is issued, the FSM SHALL move to DRAIN, wait for the final rd_valid & rd_ready beat, then go to DONE.
REQ-022 DONE SHALL last one cycle (done = 1) and then return to IDLE; a new command can be accepted on the next cycle.
REQ-023 In IDLE, DONE and DRAIN, chipselect and write SHALL be 0; writes SHALL never occur during READ.

Reset
REQ-024 While reset is high: state = IDLE; cmd_ready = 0; chipselect, write, rd_valid, done and err = 0; clken = 1; address = 0.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer on the next edge; no further write SHALL be issued and no done pulse SHALL be produced.

Configuration
REQ-026 Macro MEM_BLOCK_MASTER_CHECKSUM_EN defined: add output checksum[31:0], the mod-2^32 sum of all handshaken rd_data words. It is cleared on command accept, valid with done, and 0 after FILL.
REQ-027 Macro undefined: no checksum port and no adder logic.

Structure
REQ-028 Shared package mem_block_pkg SHALL hold the op encodings, the state enum, and the DEPTH/ADDR_W defaults.
REQ-029 One sub-module, mem_block_addr_gen, SHALL hold the address/index counter with load, enable and last-word flag; the FSM stays in the top level.

Verification
REQ-030 FILL const: addr = 100, len = 4, data = 32'hA5A5_0000, be = 4'hF -> 4 consecutive writes at 100..103, all A5A5_0000; done after the last write; err = 0.
REQ-031 FILL inc then READ: addr = 7676, len = 4, data = 10 -> memory 10..13; READ with rd_ready = 1 -> rd_data 10, 11, 12, 13 on consecutive cycles; checksum = 46 when the macro is defined.
REQ-032 Backpressure: READ len = 8 with rd_ready toggling 1,0,0,1,... -> exactly 8 beats in address order; clken = 0 on every stalled cycle.
REQ-033 Range error: addr = 7679, len = 2 -> done with err = 1, chipselect never asserted; op = 11 -> same result.
REQ-034 len = 0 -> done with err = 0 within 2 cycles of accept, no access; reset asserted on the 3rd write of len = 10 -> no later write and no done pulse; the next command completes normally.
